// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter
// Multi-digit BCD stopwatch counter. A start/stop button toggles between
// STOP and RUN, a clear button zeroes the count. While running, a prescaler
// divides clk down to TICK_HZ and each tick increments the BCD register with
// decimal carry. Every field only ever holds codes 0..9.
module stopwatch_bcd_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_start_n,
  input  logic                  key_clear_n,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  wrapped
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  localparam logic [0:0] STATE_STOP = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  // Button synchronizers and edge-detect flops (idle level is 1 = released)
  logic start_s1_q, start_s2_q, start_prev_q;
  logic clear_s1_q, clear_s2_q, clear_prev_q;
  logic start_press_s, clear_press_s;

  // Core state
  logic [0:0]          state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                wrapped_q, wrapped_d;
  logic                running_q;

  // Increment helpers
  logic                tick_s;
  logic [4*DIGITS-1:0] inc_digits_s;
  logic                all_nines_s;
  logic                carry_s;

  // Two-flop synchronizer plus previous-value flop for both buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1_q   <= 1'b1;
      start_s2_q   <= 1'b1;
      start_prev_q <= 1'b1;
      clear_s1_q   <= 1'b1;
      clear_s2_q   <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      start_s1_q   <= key_start_n;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      clear_s1_q   <= key_clear_n;
      clear_s2_q   <= clear_s1_q;
      clear_prev_q <= clear_s2_q;
    end
  end

  // A press is the falling edge of the synchronized key: one cycle per push
  assign start_press_s = ~start_s2_q & start_prev_q;
  assign clear_press_s = ~clear_s2_q & clear_prev_q;

  // Tick fires in the last prescaler cycle, only while running
  assign tick_s = (state_q == STATE_RUN) && (presc_q == PRESC_LAST);

  // Decimal increment of the whole register with ripple carry; any field at 9
  // (or an impossible code above 9) wraps to 0 and carries onward
  always_comb begin
    inc_digits_s = digits_q;
    carry_s      = 1'b1;
    all_nines_s  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] != 4'd9) begin
        all_nines_s = 1'b0;
      end else begin
        all_nines_s = all_nines_s;
      end
      if (carry_s) begin
        if (digits_q[4*i +: 4] >= 4'd9) begin
          inc_digits_s[4*i +: 4] = 4'd0;
          carry_s                = 1'b1;
        end else begin
          inc_digits_s[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          carry_s                = 1'b0;
        end
      end else begin
        inc_digits_s[4*i +: 4] = digits_q[4*i +: 4];
      end
    end
  end

  // Next-state logic: state toggle, prescaler, count and sticky wrap flag
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    digits_d  = digits_q;
    wrapped_d = wrapped_q;

    case (state_q)
      STATE_STOP: begin
        if (start_press_s) begin
          state_d = STATE_RUN;
          presc_d = PRESC_ZERO;
        end else begin
          state_d = STATE_STOP;
        end
      end
      STATE_RUN: begin
        if (start_press_s) begin
          state_d = STATE_STOP;
        end else begin
          state_d = STATE_RUN;
        end
        if (tick_s) begin
          presc_d = PRESC_ZERO;
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end
      default: begin
        state_d = STATE_STOP;
        presc_d = PRESC_ZERO;
      end
    endcase

    // Clear beats a coincident tick; it never touches the run state
    if (clear_press_s) begin
      digits_d  = '0;
      wrapped_d = 1'b0;
      presc_d   = PRESC_ZERO;
    end else if (tick_s) begin
      digits_d  = inc_digits_s;
      wrapped_d = wrapped_q | all_nines_s;
    end else begin
      digits_d  = digits_q;
    end
  end

  // Core state registers; running mirrors the registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STATE_STOP;
      presc_q   <= PRESC_ZERO;
      digits_q  <= '0;
      wrapped_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digits_q  <= digits_d;
      wrapped_q <= wrapped_d;
      running_q <= (state_d == STATE_RUN);
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter. u0 runs with DIV=10 for the
// timing, carry, stop/clear and collision steps; u1 runs with DIV=2 so the
// full 0000..9999 wrap fits in a short run.
module tb_stopwatch_bcd_counter;

  logic        clk;
  logic        rst_n;
  logic        key_start_n, key_clear_n;
  logic        key_start1_n, key_clear1_n;
  logic [15:0] digits0, digits1;
  logic        running0, running1;
  logic        wrapped0, wrapped1;

  int checks = 0;
  int errors = 0;

  stopwatch_bcd_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .key_start_n(key_start_n), .key_clear_n(key_clear_n),
    .digits(digits0), .running(running0), .wrapped(wrapped0)
  );

  stopwatch_bcd_counter #(.CLK_HZ(2), .TICK_HZ(1), .DIGITS(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .key_start_n(key_start1_n), .key_clear_n(key_clear1_n),
    .digits(digits1), .running(running1), .wrapped(wrapped1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bcd_ok(input logic [15:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (d[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  initial begin
    logic bad;
    rst_n        = 1'b0;
    key_start_n  = 1'b1;
    key_clear_n  = 1'b1;
    key_start1_n = 1'b1;
    key_clear1_n = 1'b1;

    // 1. Reset
    cyc(3);
    check("rst_digits", 32'(digits0), 32'h0000);
    check("rst_running", 32'(running0), 32'h0);
    check("rst_wrapped", 32'(wrapped0), 32'h0);
    rst_n = 1'b1;
    cyc(50);
    check("idle_digits", 32'(digits0), 32'h0000);
    check("idle_running", 32'(running0), 32'h0);

    // 2. Start: key low for 5 sampling edges, running after the 3rd
    key_start_n = 1'b0;
    cyc(2);
    check("start_lat_early", 32'(running0), 32'h0);
    cyc(1);                                   // t = 0 (action edge passed)
    check("start_lat", 32'(running0), 32'h1);
    cyc(2);                                   // t = 2, key held 5 edges
    key_start_n = 1'b1;
    cyc(7);                                   // t = 9
    check("tick1_early", 32'(digits0), 32'h0000);
    cyc(1);                                   // t = 10
    check("tick1", 32'(digits0), 32'h0001);
    cyc(10);                                  // t = 20
    check("tick2", 32'(digits0), 32'h0002);
    check("single_toggle", 32'(running0), 32'h1);

    // 3. Carry into the tens digit, fields stay 0..9 throughout
    bad = 1'b0;
    for (int i = 0; i < 79; i++) begin        // t = 99
      cyc(1);
      if (!bcd_ok(digits0)) bad = 1'b1;
    end
    check("pre_carry", 32'(digits0), 32'h0009);
    cyc(1);                                   // t = 100
    check("carry", 32'(digits0), 32'h0010);
    check("carry_fields", 32'(bad), 32'h0);

    // 5. Stop at 0042 (press at t=422, action at t=425)
    cyc(322);
    key_start_n = 1'b0;
    cyc(3);
    check("stop_running", 32'(running0), 32'h0);
    check("stop_digits", 32'(digits0), 32'h0042);
    key_start_n = 1'b1;
    cyc(100);
    check("stop_hold", 32'(digits0), 32'h0042);
    check("stop_hold_run", 32'(running0), 32'h0);
    key_clear_n = 1'b0;
    cyc(2);
    check("clear_early", 32'(digits0), 32'h0042);
    cyc(1);
    check("clear_digits", 32'(digits0), 32'h0000);
    check("clear_wrapped", 32'(wrapped0), 32'h0);
    check("clear_running", 32'(running0), 32'h0);
    key_clear_n = 1'b1;
    cyc(2);

    // 6. Clear action edge on a tick edge
    key_start_n = 1'b0;
    cyc(3);                                   // t = 0
    key_start_n = 1'b1;
    check("restart", 32'(running0), 32'h1);
    cyc(30);                                  // t = 30
    check("recount", 32'(digits0), 32'h0003);
    cyc(7);                                   // t = 37
    key_clear_n = 1'b0;
    cyc(3);                                   // t = 40: clear + tick
    check("clr_tick", 32'(digits0), 32'h0000);
    check("clr_tick_run", 32'(running0), 32'h1);
    key_clear_n = 1'b1;
    cyc(9);                                   // t = 49
    check("clr_tick_hold", 32'(digits0), 32'h0000);
    cyc(1);                                   // t = 50
    check("clr_tick_next", 32'(digits0), 32'h0001);

    // Asynchronous reset in RUN, checked before the next clk edge
    cyc(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digits", 32'(digits0), 32'h0000);
    check("arst_running", 32'(running0), 32'h0);
    check("arst_wrapped", 32'(wrapped0), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // 4. Wrap on u1 (DIV=2): tick k lands at t = 2k
    key_start1_n = 1'b0;
    cyc(3);                                   // t = 0
    key_start1_n = 1'b1;
    check("u1_start", 32'(running1), 32'h1);
    bad = 1'b0;
    for (int i = 0; i < 19998; i++) begin     // t = 19998
      cyc(1);
      if (!bcd_ok(digits1)) bad = 1'b1;
    end
    check("wrap_fields", 32'(bad), 32'h0);
    check("pre_wrap", 32'(digits1), 32'h9999);
    check("pre_wrap_flag", 32'(wrapped1), 32'h0);
    cyc(2);                                   // t = 20000
    check("wrap_digits", 32'(digits1), 32'h0000);
    check("wrap_flag", 32'(wrapped1), 32'h1);
    check("wrap_running", 32'(running1), 32'h1);
    cyc(2);                                   // t = 20002
    check("post_wrap", 32'(digits1), 32'h0001);
    check("wrap_sticky", 32'(wrapped1), 32'h1);
    key_clear1_n = 1'b0;
    cyc(3);                                   // t = 20005
    key_clear1_n = 1'b1;
    check("wrap_clr_digits", 32'(digits1), 32'h0000);
    check("wrap_clr_flag", 32'(wrapped1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
